bpsk_bit_framer: RTL and testbench
==================================

// Module: bpsk_bit_framer
// PURPOSE
//  Upstream feeder for the BPSK sine datapath: buffers payload bytes from the host side and serialises
//  them into framed bits (preamble, sync word, payload) on `data`, advancing one bit per modulator
//  `data_rdy` request. Drives `mod_ena` to gate the modulator for the duration of each frame.
//  Bit side is qualified by `clken`; the byte-input side runs every clock.
// PARAMETERS
//  FIFO_DEPTH     4      payload byte FIFO entries (power of 2, >=2)
//  PRE_BITS       16     preamble length in bits, alternating 1,0,1,0... starting with 1
//  SYNC_WORD      8'h7E  sync byte sent MSB first after the preamble
//  PAYLOAD_BYTES  4      payload bytes per frame
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst          in   1  asynchronous active-low reset
//  clken        in   1  clock enable for bit-side state (FSM, counters, shift register, pops)
//  byte_in      in   8  payload byte
//  byte_valid   in   1  byte_in valid; written when byte_valid & byte_ready
//  byte_ready   out  1  FIFO not full
//  data_rdy     in   1  modulator strobe: current bit consumed, present the next
//  data         out  1  current bit to modulator
//  mod_ena      out  1  modulator enable, high while a frame is in progress
//  frame_busy   out  1  FSM not in IDLE (same as mod_ena)
//  underrun     out  1  sticky: payload byte needed while FIFO empty
//  underrun_clr in   1  synchronous clear of underrun (wins over a same-cycle set)
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, FIFO empty, bit/byte counters=0, data=0, mod_ena=0,
//   frame_busy=0, underrun=0, byte_ready=0 while in reset, 1 from the first clock after release.
//  "step" = clken & data_rdy in a cycle where FSM != IDLE. data_rdy ignored in IDLE or when clken=0.
//  All outputs registered; a step at edge N presents the next bit on data after edge N (1-cycle latency).
//  FSM states: IDLE -> PREAMBLE -> SYNC -> PAYLOAD -> IDLE.
//   IDLE: data=0, mod_ena=0. If clken & FIFO count>=1 -> PREAMBLE, bit_cnt=0, data=1, mod_ena=1.
//   PREAMBLE: data = ~bit_cnt[0] (1,0,1,0...). Step at bit_cnt=PRE_BITS-1 -> SYNC, data=SYNC_WORD[7].
//   SYNC: data = SYNC_WORD[7-bit_cnt]. Step at bit 7 -> PAYLOAD; pops FIFO head into shift reg,
//    data = head[7], byte_cnt=0.
//   PAYLOAD: shift reg MSB first. Step at bit 7: if byte_cnt=PAYLOAD_BYTES-1 -> IDLE (mod_ena=0,
//    data=0 on next cycle; min 1 IDLE cycle between frames); else pop next byte, byte_cnt+1.
//  Underrun: any pop attempted with registered FIFO count=0 loads 8'h00 instead, sets underrun,
//   frame continues with full length. A push in that same cycle is not used for that byte.
//  FIFO: write pointer advances on byte_valid & byte_ready independent of clken; pop on clken only.
//   Simultaneous push and pop with count between 1 and FIFO_DEPTH-1: count unchanged, order kept.
//   Full: byte_ready=0; a pop at full raises byte_ready the next cycle. Pointers wrap modulo FIFO_DEPTH.
//  Frame length in bits = PRE_BITS + 8 + 8*PAYLOAD_BYTES (default 56); mod_ena high for exactly the
//   cycles between frame start and the step after the last payload bit.
//  clken=0 mid-frame: all bit-side state frozen, data/mod_ena hold; FIFO writes still accepted.
//  Reset asserted mid-frame: immediate return to reset values; FIFO contents discarded.
//  Counters sized $clog2(max(PRE_BITS,8,PAYLOAD_BYTES)) + 1; no arithmetic overflow allowed.
// TESTING
//  1. Reset release, no bytes pushed, data_rdy pulsing -> mod_ena=0, data=0, byte_ready=1, underrun=0.
//  2. Push A5,3C,FF,00 then step every 4th cycle, clken=1 -> data 1010101010101010, 01111110,
//     10100101 00111100 11111111 00000000; mod_ena high for 56 steps, then low; underrun=0.
//  3. Push only A5 and start frame -> payload A5,00,00,00; underrun=1 after 2nd payload pop;
//     underrun_clr pulse -> 0.
//  4. Push 5 bytes with no steps -> byte_ready=0 after 4th write, 5th held; first payload pop
//     -> byte_ready=1 next cycle, 5th byte accepted and sent as next frame's 1st byte.
//  5. clken=0 for 20 cycles mid-SYNC with data_rdy high -> data/mod_ena frozen, no bit skipped
//     when clken returns.
//  6. Assert rst mid-PAYLOAD -> same cycle mod_ena=0, data=0, FIFO empty; new push starts fresh
//     preamble.

Source files
------------

// File: rtl/bpsk_bit_framer.sv
// rtl/bpsk_bit_framer.sv - payload byte FIFO and preamble/sync/payload bit serialiser feeding the BPSK modulator
// Bit side advances only on clken & data_rdy; the byte side accepts writes every clock.
module bpsk_bit_framer #(
  parameter int         FIFO_DEPTH    = 4,
  parameter int         PRE_BITS      = 16,
  parameter logic [7:0] SYNC_WORD     = 8'h7E,
  parameter int         PAYLOAD_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       data_rdy,
  output logic       data,
  output logic       mod_ena,
  output logic       frame_busy,
  output logic       underrun,
  input  logic       underrun_clr
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXA = (PRE_BITS > 8) ? PRE_BITS : 8;
  localparam int MAXC = (MAXA > PAYLOAD_BYTES) ? MAXA : PAYLOAD_BYTES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_BITS - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(7);
  localparam logic [CW-1:0] BYTE_LAST = CW'(PAYLOAD_BYTES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_PAY
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]      sr_q, sr_d;
  logic            data_q, data_d;
  logic            mod_ena_q, mod_ena_d;
  logic            underrun_q, underrun_d;
  logic            byte_ready_q, byte_ready_d;

  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic            step;
  logic            pop_req;
  logic            push;
  logic            pop;
  logic            underflow;
  logic [7:0]      load_byte;
  logic [2:0]      sync_idx;

  assign step      = clken & data_rdy & (state_q != S_IDLE);
  // An empty FIFO still yields a byte: zeros keep the frame at full length.
  assign load_byte = (count_q != '0) ? mem_q[rptr_q] : 8'h00;
  assign sync_idx  = 3'd6 - bit_cnt_q[2:0];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    data_d     = data_q;
    mod_ena_d  = mod_ena_q;
    pop_req    = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_d    = 1'b0;
        mod_ena_d = 1'b0;
        if (clken && (count_q != '0)) begin
          state_d    = S_PRE;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          data_d     = 1'b1;
          mod_ena_d  = 1'b1;
        end
      end
      S_PRE: begin
        if (step) begin
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = S_SYNC;
            bit_cnt_d = '0;
            data_d    = SYNC_WORD[7];
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            data_d    = bit_cnt_q[0];
          end
        end
      end
      S_SYNC: begin
        if (step) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = S_PAY;
            pop_req    = 1'b1;
            sr_d       = load_byte;
            data_d     = load_byte[7];
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            data_d    = SYNC_WORD[sync_idx];
          end
        end
      end
      S_PAY: begin
        if (step) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (byte_cnt_q == BYTE_LAST) begin
              state_d    = S_IDLE;
              byte_cnt_d = '0;
              data_d     = 1'b0;
              mod_ena_d  = 1'b0;
            end else begin
              pop_req    = 1'b1;
              sr_d       = load_byte;
              data_d     = load_byte[7];
              byte_cnt_d = byte_cnt_q + CW'(1);
            end
          end else begin
            sr_d      = {sr_q[6:0], 1'b0};
            data_d    = sr_q[6];
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        data_d    = 1'b0;
        mod_ena_d = 1'b0;
      end
    endcase
  end

  // A push landing in the same cycle as an underflowing pop is not forwarded.
  always_comb begin
    push      = byte_valid & byte_ready_q;
    pop       = pop_req & (count_q != '0);
    underflow = pop_req & (count_q == '0);
    wptr_d    = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d    = pop ? rptr_q + AW'(1) : rptr_q;
    mem_d     = mem_q;
    if (push) begin
      mem_d[wptr_q] = byte_in;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    byte_ready_d = (count_d != FULL_CNT);
    underrun_d   = underrun_clr ? 1'b0 : (underrun_q | underflow);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      sr_q         <= '0;
      data_q       <= 1'b0;
      mod_ena_q    <= 1'b0;
      underrun_q   <= 1'b0;
      byte_ready_q <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      sr_q         <= sr_d;
      data_q       <= data_d;
      mod_ena_q    <= mod_ena_d;
      underrun_q   <= underrun_d;
      byte_ready_q <= byte_ready_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign data       = data_q;
  assign mod_ena    = mod_ena_q;
  assign frame_busy = mod_ena_q;
  assign underrun   = underrun_q;
  assign byte_ready = byte_ready_q;

endmodule

// File: tb/tb_bpsk_bit_framer.sv
// tb/tb_bpsk_bit_framer.sv - scoreboard bench for bpsk_bit_framer
module tb_bpsk_bit_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clken;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       data_rdy;
  logic       data;
  logic       mod_ena;
  logic       frame_busy;
  logic       underrun;
  logic       underrun_clr;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];
  logic       exp_q[$];
  logic       model_unr = 1'b0;
  logic       ready_after_pop = 1'b0;

  bpsk_bit_framer dut (
    .clk          (clk),
    .rst          (rst),
    .clken        (clken),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .data_rdy     (data_rdy),
    .data         (data),
    .mod_ena      (mod_ena),
    .frame_busy   (frame_busy),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    logic acc;
    acc = byte_valid & byte_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      model_q.push_back(byte_in);
      byte_valid = 1'b0;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_valid && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (byte_valid) begin
      bad++;
      $display("FAIL push_timeout byte=%02h accepted=0 want 1", b);
      byte_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input int nbits, input int freeze_at,
                           input logic [7:0] freeze_byte, input bit freeze_push);
    int n;
    logic e;
    logic [7:0] b;
    logic [7:0] sw;
    n = 0;
    while (!mod_ena && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (mod_ena !== 1'b1) begin
      bad++;
      $display("FAIL %s_start mod_ena=%0b want 1", name, mod_ena);
      return;
    end
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(~i[0]);
    sw = 8'h7E;
    for (int j = 7; j >= 0; j--) exp_q.push_back(sw[j]);
    for (int i = 0; i < nbits; i++) begin
      if (i >= 24 && ((i - 24) % 8) == 0) begin
        if (model_q.size() > 0) b = model_q.pop_front();
        else begin
          b = 8'h00;
          model_unr = 1'b1;
        end
        for (int j = 7; j >= 0; j--) exp_q.push_back(b[j]);
      end
      e = exp_q.pop_front();
      total++;
      if (data !== e || mod_ena !== 1'b1 || frame_busy !== 1'b1) begin
        bad++;
        $display("FAIL %s_bit%0d data=%0b mod_ena=%0b busy=%0b want data=%0b mod_ena=1 busy=1",
                 name, i, data, mod_ena, frame_busy, e);
      end
      total++;
      if (underrun !== model_unr) begin
        bad++;
        $display("FAIL %s_underrun_bit%0d got=%0b want=%0b", name, i, underrun, model_unr);
      end
      if (i == freeze_at) begin
        clken    = 1'b0;
        data_rdy = 1'b1;
        if (freeze_push) begin
          byte_in    = freeze_byte;
          byte_valid = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
          tick();
          total++;
          if (data !== e || mod_ena !== 1'b1) begin
            bad++;
            $display("FAIL %s_freeze%0d data=%0b mod_ena=%0b want data=%0b mod_ena=1",
                     name, k, data, mod_ena, e);
          end
        end
        clken    = 1'b1;
        data_rdy = 1'b0;
      end
      data_rdy = 1'b1;
      tick();
      data_rdy = 1'b0;
      if (i == 23) ready_after_pop = byte_ready;
      if (i == 55) begin
        total++;
        if (mod_ena !== 1'b0 || data !== 1'b0 || frame_busy !== 1'b0) begin
          bad++;
          $display("FAIL %s_end mod_ena=%0b data=%0b busy=%0b want 0 0 0",
                   name, mod_ena, data, frame_busy);
        end
      end else begin
        tick();
        tick();
        tick();
      end
    end
  endtask

  task automatic clear_underrun(input string name);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    model_unr    = 1'b0;
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL %s_clr underrun=%0b want 0", name, underrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clken = 1'b1; byte_in = 8'h00; byte_valid = 1'b0;
    data_rdy = 1'b0; underrun_clr = 1'b0;
    tick();
    tick();
    total++;
    if (byte_ready !== 1'b0 || mod_ena !== 1'b0 || data !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold ready=%0b mod_ena=%0b data=%0b unr=%0b want 0 0 0 0",
               byte_ready, mod_ena, data, underrun);
    end
    rst = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      data_rdy = k[0];
      tick();
      total++;
      if (mod_ena !== 1'b0 || data !== 1'b0 || byte_ready !== 1'b1 || underrun !== 1'b0
          || frame_busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle%0d mod_ena=%0b data=%0b ready=%0b unr=%0b busy=%0b want 0 0 1 0 0",
                 k, mod_ena, data, byte_ready, underrun, frame_busy);
      end
    end
    data_rdy = 1'b0;
  endtask

  task automatic test_frame();
    push_byte(8'hA5);
    push_byte(8'h3C);
    push_byte(8'hFF);
    push_byte(8'h00);
    run_frame("frame", 56, -1, 8'h00, 1'b0);
    tick();
    tick();
    total++;
    if (mod_ena !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL frame_after mod_ena=%0b unr=%0b want 0 0", mod_ena, underrun);
    end
  endtask

  task automatic test_underrun();
    push_byte(8'hA5);
    run_frame("underrun", 56, -1, 8'h00, 1'b0);
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL underrun_sticky got=%0b want 1", underrun);
    end
    clear_underrun("underrun");
  endtask

  task automatic test_back_to_back();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    total++;
    if (byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%0b want 0", byte_ready);
    end
    byte_in    = 8'h5A;
    byte_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (byte_ready !== 1'b0 || model_q.size() != 4) begin
      bad++;
      $display("FAIL full_hold ready=%0b queued=%0d want 0 4", byte_ready, model_q.size());
    end
    run_frame("full1", 56, -1, 8'h00, 1'b0);
    total++;
    if (ready_after_pop !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_pop got=%0b want 1", ready_after_pop);
    end
    total++;
    if (byte_valid !== 1'b0) begin
      bad++;
      $display("FAIL fifth_accept pending=%0b want 0", byte_valid);
    end
    run_frame("full2", 56, -1, 8'h00, 1'b0);
    clear_underrun("full2");
  endtask

  task automatic test_clken_freeze();
    push_byte(8'h81);
    push_byte(8'h42);
    push_byte(8'h18);
    run_frame("freeze", 56, 19, 8'hC3, 1'b1);
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL freeze_unr got=%0b want 0", underrun);
    end
  endtask

  task automatic test_reset_midframe();
    push_byte(8'hF0);
    push_byte(8'h0F);
    push_byte(8'hAA);
    push_byte(8'h55);
    run_frame("midrst", 30, -1, 8'h00, 1'b0);
    rst = 1'b0;
    #1;
    total++;
    if (mod_ena !== 1'b0 || data !== 1'b0 || frame_busy !== 1'b0 || byte_ready !== 1'b0
        || underrun !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async mod_ena=%0b data=%0b busy=%0b ready=%0b unr=%0b want 0 0 0 0 0",
               mod_ena, data, frame_busy, byte_ready, underrun);
    end
    model_q.delete();
    model_unr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (mod_ena !== 1'b0 || byte_ready !== 1'b1) begin
        bad++;
        $display("FAIL midrst_empty%0d mod_ena=%0b ready=%0b want 0 1", k, mod_ena, byte_ready);
      end
    end
    push_byte(8'hC6);
    push_byte(8'h39);
    push_byte(8'hE1);
    push_byte(8'h7F);
    run_frame("fresh", 56, -1, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_underrun();
    test_back_to_back();
    test_clken_freeze();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
